// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: direct-mapped instruction cache responder with line refill over a req/ack port
module icache_fill_ctrl #(
   parameter int LINES      = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [63:0] PC,
   input  logic        icache_flush,
   output logic        icache_r,
   output logic [31:0] instruction,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   localparam int BW  = $clog2(LINE_WORDS);
   localparam int OFF = BW + 2;
   localparam int IW  = $clog2(LINES);
   localparam int TW  = 64 - OFF - IW;
   typedef enum logic {LOOKUP, REFILL} state_t;
   state_t state, next_state;
   logic [LINES-1:0] valid;
   logic [TW-1:0] tags [LINES];
   logic [31:0] data [LINES][LINE_WORDS];
   logic [63-OFF:0] miss_line;
   logic [BW-1:0] beat;
   logic flush_pend, hit, last_ack;
   logic [IW-1:0] idx, midx;
   logic [BW-1:0] word;
   logic [TW-1:0] tag;
   logic unused_pc;
   assign idx       = PC[OFF+IW-1:OFF];
   assign word      = PC[OFF-1:2];
   assign tag       = PC[63:OFF+IW];
   assign midx      = miss_line[IW-1:0];
   assign unused_pc = ^PC[1:0];
   assign mem_addr  = {miss_line, beat, 2'b00};
   // Hit detection, same-cycle instruction return and next-state selection
   always_comb begin
      hit         = valid[idx] && tags[idx] == tag;
      icache_r    = state == LOOKUP && hit;
      instruction = data[idx][word];
      last_ack    = state == REFILL && mem_ack && beat == BW'(LINE_WORDS - 1);
      next_state  = state == LOOKUP ? ((hit || icache_flush) ? LOOKUP : REFILL)
                                    : (last_ack ? LOOKUP : REFILL);
   end
   // State register; mem_req is a registered decode of the next state
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= LOOKUP;
         mem_req <= 1'b0;
      end else begin
         state   <= next_state;
         mem_req <= next_state == REFILL;
      end
   end
   // Valid bits, miss line capture, beat counter and deferred flush tracking
   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid      <= '0;
         flush_pend <= 1'b0;
         beat       <= '0;
         miss_line  <= '0;
      end else begin
         if (icache_flush) valid <= '0;
         if (state == LOOKUP && next_state == REFILL) begin
            miss_line <= PC[63:OFF];
            beat      <= '0;
         end
         if (state == REFILL) begin
            if (mem_ack) beat <= beat + 1'b1;
            flush_pend <= last_ack ? 1'b0 : (flush_pend | icache_flush);
            if (last_ack) valid[midx] <= !(flush_pend || icache_flush);
         end
      end
   end
   // Tag and data array writes from refill beats; contents are qualified by valid
   always_ff @(posedge CLK) begin
      if (last_ack) tags[midx] <= miss_line[63-OFF:IW];
      if (state == REFILL && mem_ack) data[midx][beat] <= mem_rdata;
   end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: directed stimulus with a line-level cache model checked every cycle
module tb_icache_fill_ctrl;
   logic        CLK = 1'b0;
   logic        RESET, icache_flush, icache_r, mem_req, mem_ack;
   logic [63:0] PC, mem_addr;
   logic [31:0] instruction, mem_rdata;
   int compared = 0;
   int mismatched = 0;
   logic [31:0] exp_ins [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
   bit          m_ok = 0;
   bit          m_busy = 0;
   bit          m_pend = 0;
   bit          m_val [16];
   logic [59:0] m_tag [16];
   logic [59:0] m_line;
   int          m_beat;
   always #5 CLK = ~CLK;
   function automatic logic [31:0] fmem(input logic [63:0] a);
      return 32'h13 + 32'(a[33:2]) * 32'h00100080;
   endfunction
   assign mem_rdata = fmem(mem_addr);
   icache_fill_ctrl dut (
      .CLK(CLK), .RESET(RESET), .PC(PC), .icache_flush(icache_flush),
      .icache_r(icache_r), .instruction(instruction), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   // Model: memory is read-only, so a resident line always returns memory contents
   always @(negedge CLK) begin : model
      logic [59:0] line;
      int          idx;
      bit          hit;
      line = PC[63:4];
      idx  = int'(line[3:0]);
      hit  = !m_busy && m_val[idx] && m_tag[idx] == line;
      if (m_ok) begin
         chk("m_icache_r", {63'd0, icache_r}, {63'd0, hit});
         chk("m_mem_req", {63'd0, mem_req}, {63'd0, m_busy});
         if (m_busy) chk("m_mem_addr", mem_addr, {m_line, 4'b0} + 64'(4 * m_beat));
         if (hit) chk("m_instruction", {32'd0, instruction}, {32'd0, fmem({PC[63:2], 2'b00})});
      end
      if (RESET) begin
         m_ok   = 1;
         m_busy = 0;
         m_pend = 0;
         foreach (m_val[i]) m_val[i] = 0;
      end else if (m_ok) begin
         if (!m_busy) begin
            if (icache_flush) foreach (m_val[i]) m_val[i] = 0;
            else if (!hit) begin
               m_busy = 1;
               m_line = line;
               m_beat = 0;
               m_pend = 0;
            end
         end else begin
            if (icache_flush) begin
               foreach (m_val[i]) m_val[i] = 0;
               m_pend = 1;
            end
            if (mem_ack) begin
               m_beat++;
               if (m_beat == 4) begin
                  m_busy = 0;
                  m_tag[int'(m_line[3:0])] = m_line;
                  m_val[int'(m_line[3:0])] = !m_pend;
                  m_pend = 0;
               end
            end
         end
      end
   end
   initial begin
      RESET = 1; PC = 64'h0; icache_flush = 0; mem_ack = 0;
      step(); step();
      RESET = 0; mem_ack = 1;
      @(negedge CLK) chk("cold_miss_r", {63'd0, icache_r}, 64'd0);
      for (int b = 0; b < 4; b++) begin
         step();
         @(negedge CLK);
         chk("cold_addr", mem_addr, 64'(4 * b));
         chk("cold_req", {63'd0, mem_req}, 64'd1);
      end
      step();
      @(negedge CLK);
      chk("cold_hit_r", {63'd0, icache_r}, 64'd1);
      chk("cold_hit_ins", {32'd0, instruction}, 64'h13);
      for (int i = 1; i < 4; i++) begin
         step(); PC = 64'(4 * i);
         @(negedge CLK);
         chk("seq_r", {63'd0, icache_r}, 64'd1);
         chk("seq_ins", {32'd0, instruction}, {32'd0, exp_ins[i]});
         chk("seq_req", {63'd0, mem_req}, 64'd0);
      end
      step(); PC = 64'h100;
      @(negedge CLK) chk("evict_miss", {63'd0, icache_r}, 64'd0);
      repeat (4) step();
      step();
      @(negedge CLK) chk("evict_hit_ins", {32'd0, instruction}, 64'h04002013);
      step(); PC = 64'h0;
      @(negedge CLK) chk("evict_remiss", {63'd0, icache_r}, 64'd0);
      step();
      @(negedge CLK) chk("evict_addr", mem_addr, 64'h0);
      repeat (3) step();
      step();
      @(negedge CLK) chk("evict_back", {32'd0, instruction}, 64'h13);
      step(); PC = 64'h200; mem_ack = 0;
      @(negedge CLK) chk("slow_miss", {63'd0, icache_r}, 64'd0);
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 4; k++) begin
            step(); mem_ack = (k == 3);
            @(negedge CLK) chk("slow_addr", mem_addr, 64'h200 + 64'(4 * b));
         end
      step(); mem_ack = 1;
      @(negedge CLK) chk("slow_done", {63'd0, icache_r}, 64'd1);
      step(); PC = 64'h0;
      @(negedge CLK) chk("move_miss", {63'd0, icache_r}, 64'd0);
      step();
      step(); PC = 64'h40;
      step(); step();
      step();
      @(negedge CLK) chk("move_second_miss", {63'd0, icache_r}, 64'd0);
      step();
      @(negedge CLK) chk("move_addr", mem_addr, 64'h40);
      repeat (3) step();
      step();
      @(negedge CLK) chk("move_hit40", {32'd0, instruction}, 64'h01000813);
      step(); PC = 64'h0;
      @(negedge CLK) chk("move_hit0", {63'd0, icache_r}, 64'd1);
      step(); PC = 64'h300;
      @(negedge CLK) chk("fr_miss", {63'd0, icache_r}, 64'd0);
      step(); step();
      step(); icache_flush = 1;
      step(); icache_flush = 0;
      step(); PC = 64'h0;
      @(negedge CLK) chk("fr_0_miss", {63'd0, icache_r}, 64'd0);
      repeat (4) step();
      step();
      @(negedge CLK) chk("fr_0_refilled", {63'd0, icache_r}, 64'd1);
      step(); icache_flush = 1;
      @(negedge CLK) chk("fl_same_cycle_hit", {63'd0, icache_r}, 64'd1);
      step();
      @(negedge CLK) chk("fl_after", {63'd0, icache_r}, 64'd0);
      step(); icache_flush = 0;
      @(negedge CLK) chk("fl_no_refill", {63'd0, mem_req}, 64'd0);
      repeat (4) step();
      step();
      @(negedge CLK) chk("fl_refilled", {63'd0, icache_r}, 64'd1);
      step(); PC = 64'h40;
      @(negedge CLK) chk("rst_pre_miss", {63'd0, icache_r}, 64'd0);
      step();
      step(); RESET = 1;
      step(); RESET = 0; PC = 64'h0;
      @(negedge CLK);
      chk("rst_req", {63'd0, mem_req}, 64'd0);
      chk("rst_r", {63'd0, icache_r}, 64'd0);
      repeat (6) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
